// File: rtl/fe_pipe_ctrl_pkg.sv
// Shared types and constants for the front-end stall/flush controller.
// Hazard classes are ordered so that a lower value wins while in RUN.
package fe_pipe_ctrl_pkg;

    localparam int NUM_FE_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REDIR  = 2'd1,
        ST_REFILL = 2'd2
    } ctrl_state_e;

    typedef enum logic [2:0] {
        HZ_FREEZE   = 3'd0,
        HZ_MISPRED  = 3'd1,
        HZ_LOAD_USE = 3'd2,
        HZ_IMISS    = 3'd3,
        HZ_NONE     = 3'd4,
        HZ_REDIR    = 3'd5
    } hazard_e;

endpackage

// File: rtl/fe_pipe_ctrl_sat_counter.sv
// Saturating event counter: increments on en_i, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fe_pipe_ctrl.sv
// Stall/flush controller for the IF..EX front-end registers, including
// mispredict recovery sequencing (RUN -> REDIR -> REFILL -> RUN).
module fe_pipe_ctrl
    import fe_pipe_ctrl_pkg::*;
#(
    parameter int NUM_FE = NUM_FE_DEFAULT,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MISPRED_VALID,
    input  logic [ADDR_W-1:0] MISPRED_TARGET,
    input  logic              LOAD_USE,
    input  logic              IMEM_READY,
    input  logic              DMEM_BUSY,
    output logic              STALL_IF,
    output logic [NUM_FE-1:0] STALL_FE,
    output logic [NUM_FE-1:0] FLUSH_FE,
    output logic              FLUSH_EX,
    output logic              REDIRECT_VALID,
    output logic [ADDR_W-1:0] REDIRECT_PC,
    output logic [1:0]        CTRL_STATE,
    output logic [CNT_W-1:0]  STALL_CYCLES,
    output logic [CNT_W-1:0]  MISPRED_COUNT
);

    localparam logic [NUM_FE-1:0] FE_ALL   = {NUM_FE{1'b1}};
    localparam logic [NUM_FE-1:0] FE_FIRST = NUM_FE'(1);

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    hazard_e           hazard;
    logic              accept;

    // Classify the cycle first, then map the class onto the control outputs.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        hazard   = HZ_NONE;
        accept   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (DMEM_BUSY) begin
                    hazard = HZ_FREEZE;
                end else if (MISPRED_VALID) begin
                    hazard   = HZ_MISPRED;
                    accept   = 1'b1;
                    target_d = MISPRED_TARGET;
                    state_d  = ST_REDIR;
                end else if (LOAD_USE) begin
                    hazard = HZ_LOAD_USE;
                end else if (!IMEM_READY) begin
                    hazard = HZ_IMISS;
                end
            end
            ST_REDIR: begin
                hazard  = HZ_REDIR;
                state_d = ST_REFILL;
            end
            ST_REFILL: begin
                if (DMEM_BUSY) begin
                    hazard = HZ_FREEZE;
                end else if (!IMEM_READY) begin
                    hazard = HZ_IMISS;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        STALL_IF       = 1'b0;
        STALL_FE       = '0;
        FLUSH_FE       = '0;
        FLUSH_EX       = 1'b0;
        REDIRECT_VALID = 1'b0;
        case (hazard)
            HZ_FREEZE: begin
                STALL_IF = 1'b1;
                STALL_FE = FE_ALL;
            end
            HZ_MISPRED: begin
                STALL_IF = 1'b1;
                FLUSH_FE = FE_ALL;
                FLUSH_EX = 1'b1;
            end
            HZ_LOAD_USE: begin
                STALL_IF = 1'b1;
                STALL_FE = FE_ALL;
                FLUSH_EX = 1'b1;
            end
            // Only the IF-side register gets a bubble; younger stages drain.
            HZ_IMISS: begin
                STALL_IF = 1'b1;
                FLUSH_FE = FE_FIRST;
            end
            HZ_REDIR: begin
                REDIRECT_VALID = 1'b1;
                FLUSH_FE       = FE_ALL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_RUN;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .en_i    (STALL_IF),
        .count_o (STALL_CYCLES)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .CLK     (CLK),
        .RESET   (RESET),
        .en_i    (accept),
        .count_o (MISPRED_COUNT)
    );

    assign REDIRECT_PC = target_q;
    assign CTRL_STATE  = state_q;

    for (genvar gi = 0; gi < NUM_FE; gi++) begin : g_excl
        a_stall_flush_excl: assert property (@(posedge CLK) disable iff (!RESET)
            !(STALL_FE[gi] && FLUSH_FE[gi]));
    end

endmodule
